// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants used by the fetch stage and downstream pipeline buffers.
package cpu_pkg;
   localparam int unsigned     PC_W    = 32;
   localparam int unsigned     INSTR_W = 32;
   localparam logic [31:0]     NOP     = '0;
   localparam int unsigned     PC_INC  = 4;
endpackage

// File: rtl/pc_reg.sv
// Fetch program counter: holds on stall, steps by PC_INC, reloads past a redirect target.
module pc_reg
   import cpu_pkg::*;
#(
   parameter int unsigned     PC_W     = cpu_pkg::PC_W,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] target,
   output logic [PC_W-1:0] pc
);

   localparam logic [PC_W-1:0] INC = PC_W'(PC_INC);

   // The target itself is fetched in the redirect cycle, so the register skips past it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         pc <= RESET_PC;
      else if (redirect)
         pc <= target + INC;
      else if (!stall)
         pc <= pc + INC;
   end

endmodule

// File: rtl/if_id_stage.sv
// Instruction fetch stage with IF/ID register; one-entry skid catches read data returning during a stall.
module if_id_stage
   import cpu_pkg::*;
#(
   parameter int unsigned        PC_W     = cpu_pkg::PC_W,
   parameter int unsigned        INSTR_W  = cpu_pkg::INSTR_W,
   parameter logic [PC_W-1:0]    RESET_PC = '0,
   parameter logic [INSTR_W-1:0] NOP      = INSTR_W'(cpu_pkg::NOP)
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               iStall,
   input  logic               iBranchTaken,
   input  logic [PC_W-1:0]    iBranchTarget,
   output logic               oImemEn,
   output logic [PC_W-1:0]    oImemAddr,
   input  logic [INSTR_W-1:0] iImemRdata,
   output logic [INSTR_W-1:0] oInstr,
   output logic [PC_W-1:0]    oPC,
   output logic               oValid
);

   logic [PC_W-1:0]    pc_q;
   logic               req_valid_q;
   logic [PC_W-1:0]    req_pc_q;
   logic               hold_valid_q;
   logic [INSTR_W-1:0] hold_instr_q;
   logic [PC_W-1:0]    fetch_addr;

   pc_reg #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clock    (clock),
      .reset_n  (reset_n),
      .stall    (iStall),
      .redirect (iBranchTaken),
      .target   (iBranchTarget),
      .pc       (pc_q)
   );

   // Redirect bypasses pc_q so the target is read in the same cycle the branch resolves.
   always_comb begin
      fetch_addr = iBranchTaken ? iBranchTarget : pc_q;
      oImemAddr  = fetch_addr;
      oImemEn    = reset_n & (iBranchTaken | ~iStall);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         req_valid_q  <= 1'b0;
         req_pc_q     <= '0;
         hold_valid_q <= 1'b0;
         hold_instr_q <= '0;
         oInstr       <= NOP;
         oPC          <= '0;
         oValid       <= 1'b0;
      end else if (iBranchTaken) begin
         req_valid_q  <= 1'b1;
         req_pc_q     <= fetch_addr;
         hold_valid_q <= 1'b0;
         oInstr       <= NOP;
         oValid       <= 1'b0;
      end else if (iStall) begin
         // Only the first stalled cycle carries real read data; later cycles had no read enabled.
         if (req_valid_q && !hold_valid_q) begin
            hold_instr_q <= iImemRdata;
            hold_valid_q <= 1'b1;
         end
      end else begin
         req_valid_q  <= 1'b1;
         req_pc_q     <= fetch_addr;
         hold_valid_q <= 1'b0;
         if (req_valid_q) begin
            oInstr <= hold_valid_q ? hold_instr_q : iImemRdata;
            oPC    <= req_pc_q;
            oValid <= 1'b1;
         end else begin
            oInstr <= NOP;
            oValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: expected fetch stream is queued by the stimulus and checked at decode.
module tb_if_id_stage;

   logic        clock;
   logic        reset_n;
   logic        iStall;
   logic        iBranchTaken;
   logic [31:0] iBranchTarget;
   logic        oImemEn;
   logic [31:0] oImemAddr;
   logic [31:0] iImemRdata;
   logic [31:0] oInstr;
   logic [31:0] oPC;
   logic        oValid;

   int tests = 0;
   int fails = 0;

   logic [31:0] exp_q[$];
   logic [31:0] last_pc;
   logic [31:0] last_instr;
   logic        held;

   if_id_stage dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .iStall        (iStall),
      .iBranchTaken  (iBranchTaken),
      .iBranchTarget (iBranchTarget),
      .oImemEn       (oImemEn),
      .oImemAddr     (oImemAddr),
      .iImemRdata    (iImemRdata),
      .oInstr        (oInstr),
      .oPC           (oPC),
      .oValid        (oValid)
   );

   initial clock = 1'b0;
   always #10 clock = ~clock;

   // Memory word is the address with halves swapped, so PC and data paths cannot be confused.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]};
   endfunction

   // Synchronous 1-cycle memory; garbage when no read was enabled, exposing skid misuse.
   always @(posedge clock)
      iImemRdata <= oImemEn ? mem_word(oImemAddr) : 32'hDEAD_BEEF;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      tests++;
      assert (obs === want) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic drive(input logic s, input logic b, input logic [31:0] t);
      iStall        = s;
      iBranchTaken  = b;
      iBranchTarget = t;
   endtask

   always @(posedge clock) held <= iStall && !iBranchTaken;

   // Decode-side monitor: stalled edges must hold, every other valid pops the next expected PC.
   always @(negedge clock) begin
      if (held) begin
         chk("hold_pc", oPC, last_pc);
         chk("hold_instr", oInstr, last_instr);
      end else if (oValid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", {31'b0, oValid}, 32'd0);
         end else begin
            logic [31:0] p;
            p = exp_q.pop_front();
            chk("out_pc", oPC, p);
            chk("out_instr", oInstr, mem_word(p));
            last_pc    = p;
            last_instr = mem_word(p);
         end
      end
   end

   initial begin
      held    = 1'b0;
      reset_n = 1'b1;
      drive(1'b0, 1'b0, 32'h0);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_valid", {31'b0, oValid}, 32'd0);
      chk("rst_instr", oInstr, 32'h0);
      chk("rst_pc", oPC, 32'h0);
      chk("rst_en", {31'b0, oImemEn}, 32'd0);

      // Cycle 1: release, fetch from RESET_PC.
      @(negedge clock);
      reset_n = 1'b1;
      foreach (exp_q[i]) ;
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C,
                32'h100, 32'h104, 32'h200, 32'h400, 32'h404, 32'h408};
      #1;
      chk("first_en", {31'b0, oImemEn}, 32'd1);
      chk("first_addr", oImemAddr, 32'h0);
      @(negedge clock);
      chk("valid_after_e1", {31'b0, oValid}, 32'd0);

      // Cycles 6-8: stall while 0x10 is in flight.
      repeat (4) @(negedge clock);
      for (int unsigned k = 0; k < 3; k++) begin
         drive(1'b1, 1'b0, 32'h0);
         #1 chk("stall_en", {31'b0, oImemEn}, 32'd0);
         @(negedge clock);
         chk("stall_pc", oPC, 32'hC);
      end
      drive(1'b0, 1'b0, 32'h0);

      // Cycle 13: redirect to 0x100 while 0x20 is in flight.
      repeat (4) @(negedge clock);
      drive(1'b0, 1'b1, 32'h100);
      #1 chk("br_addr", oImemAddr, 32'h100);
      @(negedge clock);
      drive(1'b0, 1'b0, 32'h0);
      chk("br_squash", {31'b0, oValid}, 32'd0);

      // Cycle 16: redirect and stall together; redirect wins.
      repeat (2) @(negedge clock);
      drive(1'b1, 1'b1, 32'h200);
      #1;
      chk("brst_en", {31'b0, oImemEn}, 32'd1);
      chk("brst_addr", oImemAddr, 32'h200);
      @(negedge clock);
      drive(1'b0, 1'b0, 32'h0);
      chk("brst_squash", {31'b0, oValid}, 32'd0);

      // Cycles 18-19: back-to-back redirects, latest target wins.
      @(negedge clock);
      drive(1'b0, 1'b1, 32'h300);
      @(negedge clock);
      chk("b2b_squash1", {31'b0, oValid}, 32'd0);
      drive(1'b0, 1'b1, 32'h400);
      @(negedge clock);
      chk("b2b_squash2", {31'b0, oValid}, 32'd0);
      drive(1'b0, 1'b0, 32'h0);
      repeat (3) @(negedge clock);
      #2 chk("drain_pre_reset", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset pulse between edges; 0x40C in flight is discarded.
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", {31'b0, oValid}, 32'd0);
      chk("mid_rst_instr", oInstr, 32'h0);
      chk("mid_rst_pc", oPC, 32'h0);
      chk("mid_rst_en", {31'b0, oImemEn}, 32'd0);
      #1 reset_n = 1'b1;
      exp_q = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
      #1;
      chk("restart_en", {31'b0, oImemEn}, 32'd1);
      chk("restart_addr", oImemAddr, 32'h0);
      @(negedge clock);
      chk("restart_bubble", {31'b0, oValid}, 32'd0);

      // Wrap: redirect to 0xFFFFFFF8 so pc_q reaches 0xFFFFFFFC and rolls to 0.
      @(negedge clock);
      drive(1'b0, 1'b1, 32'hFFFF_FFF8);
      @(negedge clock);
      drive(1'b0, 1'b0, 32'h0);
      #1 chk("wrap_addr_top", oImemAddr, 32'hFFFF_FFFC);
      @(negedge clock);
      #1 chk("wrap_addr_zero", oImemAddr, 32'h0);
      repeat (3) @(negedge clock);
      #2 chk("drain_end", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #20000;
      fails++;
      $display("FAIL timeout: simulation did not complete, observed running expected finished");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end

endmodule
